ascon_perm_ctrl: RTL and testbench

Sequencer for the bit-serial 320-bit ASCON permutation datapath. It drives the select of the 4:1 state multiplexer and the state-register enable, counts bit-slices and rounds, and issues the per-round constant. It runs either p^a (12 rounds) or p^b (6 rounds) per request and signals completion with a one-cycle pulse. It sits between the mode/AEAD top-level FSM and the state register plus mux datapath.

---
 rtl/ascon_perm_ctrl.sv | 135 +++++++++++++
 tb/tb_ascon_perm_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_perm_ctrl.sv
// Control sequencer for the bit-serial ASCON permutation: steps LOAD, SUB slices and LIN
// per round, drives the state mux and register enable, and issues the per-round constant.
module ascon_perm_ctrl #(
  parameter int WIDTH    = 320,
  parameter int SLICES   = 64,
  parameter int ROUNDS_A = 12,
  parameter int ROUNDS_B = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       mode_b,
  input  logic       abort,
  output logic       ready,
  output logic       busy,
  output logic       done,
  output logic [1:0] mux_sel,
  output logic       state_en,
  output logic [5:0] slice_idx,
  output logic [7:0] round_const,
  output logic [2:0] state_dbg
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LOAD = 3'd1;
  localparam logic [2:0] SUB  = 3'd2;
  localparam logic [2:0] LIN  = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  localparam logic [5:0] SLICE_LAST    = 6'(SLICES - 1);
  localparam logic [3:0] ROUND_LAST    = 4'(ROUNDS_A - 1);
  localparam logic [3:0] ROUND_B_FIRST = 4'(ROUNDS_A - ROUNDS_B);

  // The state is five 64-bit lanes, so one slice cycle touches one bit of every lane.
  if (WIDTH != 5 * SLICES) begin : g_bad_width
    $error("ascon_perm_ctrl: WIDTH must equal 5*SLICES");
  end
  if (SLICES < 2 || SLICES > 64) begin : g_bad_slices
    $error("ascon_perm_ctrl: SLICES must be in 2..64");
  end
  if (ROUNDS_B > ROUNDS_A || ROUNDS_A > 16 || ROUNDS_B < 1) begin : g_bad_rounds
    $error("ascon_perm_ctrl: need 1 <= ROUNDS_B <= ROUNDS_A <= 16");
  end

  logic [2:0] state_q;
  logic [5:0] slice_q;
  logic [3:0] round_q;

  // Handshake: a request is accepted at a rising edge where start=1 and ready=1 (IDLE) and
  // abort=0; start at any other time is dropped, never queued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      slice_q <= 6'd0;
      round_q <= 4'd0;
    end else if (abort && state_q != IDLE) begin
      state_q <= IDLE;
      slice_q <= 6'd0;
      round_q <= 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !abort) begin
            state_q <= LOAD;
            // p^b runs the last ROUNDS_B rounds of p^a, so it simply starts further in.
            round_q <= mode_b ? ROUND_B_FIRST : 4'd0;
          end
        end
        LOAD: begin
          state_q <= SUB;
          slice_q <= 6'd0;
        end
        SUB: begin
          if (slice_q == SLICE_LAST) begin
            state_q <= LIN;
            slice_q <= 6'd0;
          end else begin
            slice_q <= slice_q + 6'd1;
          end
        end
        LIN: begin
          if (round_q == ROUND_LAST) begin
            state_q <= DONE;
            round_q <= 4'd0;
          end else begin
            state_q <= SUB;
            round_q <= round_q + 4'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          slice_q <= 6'd0;
          round_q <= 4'd0;
        end
      endcase
    end
  end

  always_comb begin
    ready       = (state_q == IDLE);
    busy        = (state_q != IDLE);
    done        = (state_q == DONE);
    mux_sel     = 2'd0;
    state_en    = 1'b0;
    slice_idx   = 6'd0;
    round_const = 8'd0;
    case (state_q)
      LOAD: begin
        mux_sel  = 2'd1;
        state_en = 1'b1;
      end
      SUB: begin
        mux_sel     = 2'd2;
        state_en    = 1'b1;
        slice_idx   = slice_q;
        round_const = {4'hF - round_q, round_q};
      end
      LIN: begin
        mux_sel     = 2'd3;
        state_en    = 1'b1;
        round_const = {4'hF - round_q, round_q};
      end
      default: begin
        mux_sel  = 2'd0;
        state_en = 1'b0;
      end
    endcase
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_ascon_perm_ctrl.sv
// Self-checking bench for ascon_perm_ctrl: per-cycle output traces from a loop-built
// reference of the round/slice schedule, with randomized mode, abort and stray-start points.
module tb_ascon_perm_ctrl;
  localparam int SLICES   = 64;
  localparam int ROUNDS_A = 12;
  localparam int ROUNDS_B = 6;
  localparam int W        = 20;
  localparam int RUN_LEN  = 1 + ROUNDS_A * (SLICES + 1);
  localparam logic [W-1:0] IDLE_V = {1'b1, 19'd0};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       mode_b = 1'b0;
  logic       abort = 1'b0;
  logic       ready, busy, done, state_en;
  logic [1:0] mux_sel;
  logic [5:0] slice_idx;
  logic [7:0] round_const;
  logic [2:0] state_dbg;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];
  logic [7:0] rc_tab [12] = '{8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
                              8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B};
  logic [W-1:0] obs;

  ascon_perm_ctrl #(.WIDTH(320), .SLICES(SLICES), .ROUNDS_A(ROUNDS_A), .ROUNDS_B(ROUNDS_B)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode_b(mode_b), .abort(abort),
    .ready(ready), .busy(busy), .done(done), .mux_sel(mux_sel), .state_en(state_en),
    .slice_idx(slice_idx), .round_const(round_const), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  assign obs = {ready, busy, done, mux_sel, state_en, slice_idx, round_const};

  function automatic logic [W-1:0] pk(input logic rdy, input logic bsy, input logic dn,
                                      input logic [1:0] ms, input logic en,
                                      input logic [5:0] sl, input logic [7:0] rc);
    return {rdy, bsy, dn, ms, en, sl, rc};
  endfunction

  // reference model: expected per-cycle outputs from LOAD through DONE
  task automatic push_run(input int rounds);
    int first;
    first = ROUNDS_A - rounds;
    exp_q.push_back(pk(1'b0, 1'b1, 1'b0, 2'd1, 1'b1, 6'd0, 8'd0));
    for (int r = 0; r < rounds; r++) begin
      for (int s = 0; s < SLICES; s++)
        exp_q.push_back(pk(1'b0, 1'b1, 1'b0, 2'd2, 1'b1, 6'(s), rc_tab[first + r]));
      exp_q.push_back(pk(1'b0, 1'b1, 1'b0, 2'd3, 1'b1, 6'd0, rc_tab[first + r]));
    end
    exp_q.push_back(pk(1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 6'd0, 8'd0));
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(IDLE_V);
  endtask

  task automatic truncate(input int keep);
    while (exp_q.size() > keep) void'(exp_q.pop_back());
  endtask

  // driver: optional start, then one compare per cycle at the falling edge while the
  // expected queue lasts; events fire right after the compare of the given cycle index
  task automatic run_trace(input logic do_start, input logic m, input int abort_at,
                           input int pulse_a, input int pulse_b, input int drop_at,
                           output int en_cnt, output int done_cnt);
    logic [W-1:0] e;
    int idx;
    idx = 0;
    en_cnt = 0;
    done_cnt = 0;
    if (do_start) begin
      start = 1'b1;
      mode_b = m;
    end
    while (exp_q.size() > 0) begin
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      mode_b = 1'($urandom_range(0, 1));
      e = exp_q.pop_front();
      n_tests++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL trace[%0d]: got %h want %h", idx, obs, e);
      end
      en_cnt += int'(state_en);
      done_cnt += int'(done);
      if (idx == abort_at) abort = 1'b1;
      if (idx == pulse_a || idx == pulse_b) start = 1'b1;
      if (idx == drop_at) begin
        #1 rst_n = 1'b0;
        #1;
        n_tests++;
        if (obs !== IDLE_V) begin
          n_fail++;
          $display("FAIL async_reset: got %h want %h", obs, IDLE_V);
        end
        exp_q.delete();
      end
      idx++;
    end
  endtask

  task automatic test_reset();
    int en_cnt, done_cnt;
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      n_tests++;
      if (obs !== IDLE_V) begin
        n_fail++;
        $display("FAIL reset_values: got %h want %h", obs, IDLE_V);
      end
    end
    rst_n = 1'b1;
    push_idle(20);
    run_trace(1'b0, 1'b0, -1, -1, -1, -1, en_cnt, done_cnt);
  endtask

  task automatic test_run(input logic m);
    int en_cnt, done_cnt, rounds;
    rounds = m ? ROUNDS_B : ROUNDS_A;
    push_run(rounds);
    push_idle(1);
    run_trace(1'b1, m, -1, -1, -1, -1, en_cnt, done_cnt);
    n_tests++;
    if (en_cnt !== 1 + rounds * (SLICES + 1)) begin
      n_fail++;
      $display("FAIL state_en_count mode_b=%0d: got %0d want %0d", m, en_cnt, 1 + rounds * (SLICES + 1));
    end
    n_tests++;
    if (done_cnt !== 1) begin
      n_fail++;
      $display("FAIL done_count mode_b=%0d: got %0d want 1", m, done_cnt);
    end
  endtask

  task automatic test_abort();
    int en_cnt, done_cnt, at;
    for (int k = 0; k < 3; k++) begin
      at = (k == 0) ? 1 + 3 * (SLICES + 1) + 10 : int'($urandom_range(0, RUN_LEN - 1));
      push_run(ROUNDS_A);
      truncate(at + 1);
      push_idle(4);
      run_trace(1'b1, 1'b0, at, -1, -1, -1, en_cnt, done_cnt);
      n_tests++;
      if (done_cnt !== 0 || en_cnt !== at + 1) begin
        n_fail++;
        $display("FAIL abort_at_%0d: got done=%0d en=%0d want done=0 en=%0d", at, done_cnt, en_cnt, at + 1);
      end
    end
    test_run(1'b0);
  endtask

  task automatic test_ignored_start();
    int en_cnt, done_cnt, sub_at;
    sub_at = 1 + int'($urandom_range(0, ROUNDS_A - 1)) * (SLICES + 1) + int'($urandom_range(0, SLICES - 1));
    push_run(ROUNDS_A);
    push_idle(3);
    run_trace(1'b1, 1'b0, -1, sub_at, RUN_LEN, -1, en_cnt, done_cnt);
    n_tests++;
    if (en_cnt !== RUN_LEN || done_cnt !== 1) begin
      n_fail++;
      $display("FAIL ignored_start: got en=%0d done=%0d want en=%0d done=1", en_cnt, done_cnt, RUN_LEN);
    end
    start = 1'b1;
    abort = 1'b1;
    mode_b = 1'($urandom_range(0, 1));
    push_idle(4);
    run_trace(1'b0, 1'b0, -1, -1, -1, -1, en_cnt, done_cnt);
  endtask

  task automatic test_back_to_back();
    int en_cnt, done_cnt, rounds;
    logic m;
    for (int k = 0; k < 4; k++) begin
      m = 1'($urandom_range(0, 1));
      rounds = m ? ROUNDS_B : ROUNDS_A;
      push_run(rounds);
      push_idle(1);
      run_trace(1'b1, m, -1, -1, -1, -1, en_cnt, done_cnt);
      n_tests++;
      if (done_cnt !== 1) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: got done=%0d want 1", k, done_cnt);
      end
    end
  endtask

  task automatic test_async_reset();
    int en_cnt, done_cnt;
    push_run(ROUNDS_A);
    truncate(1 + 5 * (SLICES + 1) + SLICES + 1);
    run_trace(1'b1, 1'b0, -1, -1, -1, 1 + 5 * (SLICES + 1) + SLICES, en_cnt, done_cnt);
    repeat (2) begin
      @(negedge clk);
      n_tests++;
      if (obs !== IDLE_V) begin
        n_fail++;
        $display("FAIL reset_hold: got %h want %h", obs, IDLE_V);
      end
    end
    rst_n = 1'b1;
    push_idle(10);
    run_trace(1'b0, 1'b0, -1, -1, -1, -1, en_cnt, done_cnt);
    n_tests++;
    if (done_cnt !== 0) begin
      n_fail++;
      $display("FAIL no_done_after_reset: got %0d want 0", done_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_run(1'b0);
    test_run(1'b1);
    test_abort();
    test_ignored_start();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
